// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, responder FSM state types and the burst legality check.
package axi3_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_32B = 3'd5;
  localparam int         AXI_BEAT_LSB = 5;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  // Only full-width FIXED or INCR bursts are served; anything else answers SLVERR.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_32B) ||
           ((burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR));
  endfunction

endpackage

// File: rtl/axi3_mem_responder_if.sv
// AXI3 port bundle between the bank BIU (master) and the memory responder (slave).
interface axi3_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6
);
  logic                    mem_axi3_arvalid_i;
  logic                    mem_axi3_arready_o;
  logic [ID_WIDTH-1:0]     mem_axi3_arid_i;
  logic [ADDR_WIDTH-1:0]   mem_axi3_araddr_i;
  logic [3:0]              mem_axi3_arlen_i;
  logic [2:0]              mem_axi3_arsize_i;
  logic [1:0]              mem_axi3_arburst_i;

  logic                    mem_axi3_rvalid_o;
  logic                    mem_axi3_rready_i;
  logic [ID_WIDTH-1:0]     mem_axi3_rid_o;
  logic [DATA_WIDTH-1:0]   mem_axi3_rdata_o;
  logic [1:0]              mem_axi3_rresp_o;
  logic                    mem_axi3_rlast_o;

  logic                    mem_axi3_awvalid_i;
  logic                    mem_axi3_awready_o;
  logic [ID_WIDTH-1:0]     mem_axi3_awid_i;
  logic [ADDR_WIDTH-1:0]   mem_axi3_awaddr_i;
  logic [3:0]              mem_axi3_awlen_i;
  logic [2:0]              mem_axi3_awsize_i;
  logic [1:0]              mem_axi3_awburst_i;

  logic                    mem_axi3_wvalid_i;
  logic                    mem_axi3_wready_o;
  logic [ID_WIDTH-1:0]     mem_axi3_wid_i;
  logic [DATA_WIDTH-1:0]   mem_axi3_wdata_i;
  logic [DATA_WIDTH/8-1:0] mem_axi3_wstrb_i;
  logic                    mem_axi3_wlast_i;

  logic                    mem_axi3_bvalid_o;
  logic                    mem_axi3_bready_i;
  logic [ID_WIDTH-1:0]     mem_axi3_bid_o;
  logic [1:0]              mem_axi3_bresp_o;

  modport slave (
    input  mem_axi3_arvalid_i, mem_axi3_arid_i, mem_axi3_araddr_i, mem_axi3_arlen_i,
           mem_axi3_arsize_i, mem_axi3_arburst_i, mem_axi3_rready_i,
           mem_axi3_awvalid_i, mem_axi3_awid_i, mem_axi3_awaddr_i, mem_axi3_awlen_i,
           mem_axi3_awsize_i, mem_axi3_awburst_i, mem_axi3_wvalid_i, mem_axi3_wid_i,
           mem_axi3_wdata_i, mem_axi3_wstrb_i, mem_axi3_wlast_i, mem_axi3_bready_i,
    output mem_axi3_arready_o, mem_axi3_rvalid_o, mem_axi3_rid_o, mem_axi3_rdata_o,
           mem_axi3_rresp_o, mem_axi3_rlast_o, mem_axi3_awready_o, mem_axi3_wready_o,
           mem_axi3_bvalid_o, mem_axi3_bid_o, mem_axi3_bresp_o
  );

  modport master (
    output mem_axi3_arvalid_i, mem_axi3_arid_i, mem_axi3_araddr_i, mem_axi3_arlen_i,
           mem_axi3_arsize_i, mem_axi3_arburst_i, mem_axi3_rready_i,
           mem_axi3_awvalid_i, mem_axi3_awid_i, mem_axi3_awaddr_i, mem_axi3_awlen_i,
           mem_axi3_awsize_i, mem_axi3_awburst_i, mem_axi3_wvalid_i, mem_axi3_wid_i,
           mem_axi3_wdata_i, mem_axi3_wstrb_i, mem_axi3_wlast_i, mem_axi3_bready_i,
    input  mem_axi3_arready_o, mem_axi3_rvalid_o, mem_axi3_rid_o, mem_axi3_rdata_o,
           mem_axi3_rresp_o, mem_axi3_rlast_o, mem_axi3_awready_o, mem_axi3_wready_o,
           mem_axi3_bvalid_o, mem_axi3_bid_o, mem_axi3_bresp_o
  );

endinterface

// File: rtl/axi3_mem_array.sv
// Beat-wide memory: one asynchronous read port, one synchronous byte-enabled write port.
module axi3_mem_array #(
  parameter int DATA_WIDTH = 256,
  parameter int MEM_IDX_W  = 10
) (
  input  logic                    clk_i,
  input  logic [MEM_IDX_W-1:0]    rd_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    we_i,
  input  logic [MEM_IDX_W-1:0]    wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i
);

  localparam int DEPTH  = 1 << MEM_IDX_W;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Reads see the pre-write contents during a same-cycle write.
  assign rd_data_o = mem_q[rd_idx_i];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (we_i && wr_strb_i[b]) begin
        mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi3_mem_responder.sv
// AXI3 slave terminating the BIU master port onto an on-chip beat memory;
// independent read (AR/R) and write (AW/W/B) state machines.
module axi3_mem_responder
  import axi3_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int MEM_IDX_W  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axi3_mem_responder_if.slave  axi
);

  localparam int IDX_HI = AXI_BEAT_LSB + MEM_IDX_W - 1;
  localparam logic [MEM_IDX_W-1:0] IDX_ONE = {{(MEM_IDX_W-1){1'b0}}, 1'b1};

  rd_state_t             rd_state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [1:0]            rresp_q;
  logic [MEM_IDX_W-1:0]  rd_idx_q;
  logic [3:0]            rd_len_q, rd_cnt_q;
  logic                  rd_fixed_q;

  wr_state_t             wr_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   wr_id_q, bid_q;
  logic [1:0]            bresp_q;
  logic [MEM_IDX_W-1:0]  wr_idx_q;
  logic [3:0]            wr_len_q;
  logic [4:0]            wr_cnt_q;
  logic                  wr_fixed_q, wr_err_q, wr_mism_q;

  logic [DATA_WIDTH-1:0] mem_rd_data_s;
  logic                  mem_we_s;
  logic                  wr_beat_mism_s;
  logic                  unused_addr_s;

  // Read channel FSM; the error flag is folded directly into the held rresp.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= AXI_RESP_OKAY;
      rd_idx_q   <= '0;
      rd_len_q   <= 4'd0;
      rd_cnt_q   <= 4'd0;
      rd_fixed_q <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (axi.mem_axi3_arvalid_i) begin
            rid_q      <= axi.mem_axi3_arid_i;
            rd_idx_q   <= axi.mem_axi3_araddr_i[IDX_HI:AXI_BEAT_LSB];
            rd_len_q   <= axi.mem_axi3_arlen_i;
            rd_cnt_q   <= 4'd0;
            rd_fixed_q <= (axi.mem_axi3_arburst_i == AXI_BURST_FIXED);
            rresp_q    <= burst_err(axi.mem_axi3_arsize_i, axi.mem_axi3_arburst_i) ?
                          AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rlast_q    <= (axi.mem_axi3_arlen_i == 4'd0);
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.mem_axi3_rready_i) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              rd_cnt_q <= rd_cnt_q + 4'd1;
              rlast_q  <= ((rd_cnt_q + 4'd1) == rd_len_q);
              if (!rd_fixed_q) begin
                rd_idx_q <= rd_idx_q + IDX_ONE;
              end
            end
          end
        end
        default: begin
          rvalid_q   <= 1'b0;
          rlast_q    <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign wr_beat_mism_s = (axi.mem_axi3_wid_i != wr_id_q) ||
                          (axi.mem_axi3_wlast_i && (wr_cnt_q != {1'b0, wr_len_q}));
  assign mem_we_s = wready_q && axi.mem_axi3_wvalid_i && !wr_err_q &&
                    (wr_cnt_q <= {1'b0, wr_len_q});

  // Write channel FSM; beat counter saturates so overlong bursts cannot wrap into range.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_id_q    <= '0;
      bid_q      <= '0;
      bresp_q    <= AXI_RESP_OKAY;
      wr_idx_q   <= '0;
      wr_len_q   <= 4'd0;
      wr_cnt_q   <= 5'd0;
      wr_fixed_q <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_mism_q  <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (axi.mem_axi3_awvalid_i) begin
            wr_id_q    <= axi.mem_axi3_awid_i;
            wr_idx_q   <= axi.mem_axi3_awaddr_i[IDX_HI:AXI_BEAT_LSB];
            wr_len_q   <= axi.mem_axi3_awlen_i;
            wr_cnt_q   <= 5'd0;
            wr_fixed_q <= (axi.mem_axi3_awburst_i == AXI_BURST_FIXED);
            wr_err_q   <= burst_err(axi.mem_axi3_awsize_i, axi.mem_axi3_awburst_i);
            wr_mism_q  <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi.mem_axi3_wvalid_i) begin
            wr_cnt_q <= (wr_cnt_q == 5'd16) ? wr_cnt_q : (wr_cnt_q + 5'd1);
            if (!wr_fixed_q) begin
              wr_idx_q <= wr_idx_q + IDX_ONE;
            end
            if (axi.mem_axi3_wlast_i) begin
              bresp_q    <= (wr_err_q || wr_mism_q || wr_beat_mism_s) ?
                            AXI_RESP_SLVERR : AXI_RESP_OKAY;
              bid_q      <= wr_id_q;
              bvalid_q   <= 1'b1;
              wready_q   <= 1'b0;
              wr_state_q <= W_RESP;
            end else begin
              wr_mism_q <= wr_mism_q | wr_beat_mism_s;
            end
          end
        end
        W_RESP: begin
          if (axi.mem_axi3_bready_i) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          bvalid_q   <= 1'b0;
          wready_q   <= 1'b0;
          awready_q  <= 1'b1;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  axi3_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_IDX_W  (MEM_IDX_W)
  ) u_mem (
    .clk_i     (clk_i),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (mem_rd_data_s),
    .we_i      (mem_we_s),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (axi.mem_axi3_wdata_i),
    .wr_strb_i (axi.mem_axi3_wstrb_i)
  );

  // Gate data with rvalid so never-written (unknown) locations do not leak out when idle.
  assign axi.mem_axi3_rdata_o   = rvalid_q ? mem_rd_data_s : '0;
  assign axi.mem_axi3_arready_o = arready_q;
  assign axi.mem_axi3_rvalid_o  = rvalid_q;
  assign axi.mem_axi3_rid_o     = rid_q;
  assign axi.mem_axi3_rresp_o   = rresp_q;
  assign axi.mem_axi3_rlast_o   = rlast_q;
  assign axi.mem_axi3_awready_o = awready_q;
  assign axi.mem_axi3_wready_o  = wready_q;
  assign axi.mem_axi3_bvalid_o  = bvalid_q;
  assign axi.mem_axi3_bid_o     = bid_q;
  assign axi.mem_axi3_bresp_o   = bresp_q;

  assign unused_addr_s = ^{axi.mem_axi3_araddr_i[ADDR_WIDTH-1:IDX_HI+1],
                           axi.mem_axi3_araddr_i[AXI_BEAT_LSB-1:0],
                           axi.mem_axi3_awaddr_i[ADDR_WIDTH-1:IDX_HI+1],
                           axi.mem_axi3_awaddr_i[AXI_BEAT_LSB-1:0]};

endmodule

// File: tb/tb_axi3_mem_responder.sv
// Directed self-checking bench for axi3_mem_responder.
module tb_axi3_mem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  axi3_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .ID_WIDTH(6)) bus ();

  axi3_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (256),
    .ID_WIDTH   (6),
    .MEM_IDX_W  (10)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .axi   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [255:0] wd [4];
  logic [31:0]  ws [4];
  logic [255:0] rd_data [16];
  logic [1:0]   rd_resp [16];
  logic         rd_last [16];
  logic [5:0]   rd_id   [16];
  int           rd_n;
  int           rd_cyc;
  logic [1:0]   wr_bresp;
  logic [5:0]   wr_bid;

  logic [255:0] dat_a, dat_b, dat_p1, dat_w0, dat_w1, dat_m1, dat_old4, dat_new4, dat_x;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [264:0] obs, input logic [264:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int last_beat, input logic [5:0] wid);
    int n;
    bus.mem_axi3_awid_i    = id;
    bus.mem_axi3_awaddr_i  = addr;
    bus.mem_axi3_awlen_i   = len;
    bus.mem_axi3_awsize_i  = size;
    bus.mem_axi3_awburst_i = burst;
    bus.mem_axi3_awvalid_i = 1'b1;
    n = 0;
    while (!bus.mem_axi3_awready_o && n < 20) begin step(); n++; end
    check("awready_wait", bus.mem_axi3_awready_o, 1'b1);
    step();
    bus.mem_axi3_awvalid_i = 1'b0;
    check("wready_after_aw", bus.mem_axi3_wready_o, 1'b1);
    for (int b = 0; b <= last_beat; b++) begin
      bus.mem_axi3_wvalid_i = 1'b1;
      bus.mem_axi3_wdata_i  = wd[b];
      bus.mem_axi3_wstrb_i  = ws[b];
      bus.mem_axi3_wlast_i  = (b == last_beat);
      bus.mem_axi3_wid_i    = wid;
      step();
    end
    bus.mem_axi3_wvalid_i = 1'b0;
    bus.mem_axi3_wlast_i  = 1'b0;
    check("bvalid_after_wlast", bus.mem_axi3_bvalid_o, 1'b1);
    wr_bresp = bus.mem_axi3_bresp_o;
    wr_bid   = bus.mem_axi3_bid_o;
    step();
    check("bvalid_clear", bus.mem_axi3_bvalid_o, 1'b0);
  endtask

  task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int n;
    int cyc;
    bit held;
    logic [264:0] snap;
    bus.mem_axi3_arid_i    = id;
    bus.mem_axi3_araddr_i  = addr;
    bus.mem_axi3_arlen_i   = len;
    bus.mem_axi3_arsize_i  = size;
    bus.mem_axi3_arburst_i = burst;
    bus.mem_axi3_arvalid_i = 1'b1;
    n = 0;
    while (!bus.mem_axi3_arready_o && n < 20) begin step(); n++; end
    check("arready_wait", bus.mem_axi3_arready_o, 1'b1);
    step();
    bus.mem_axi3_arvalid_i = 1'b0;
    check("rvalid_first", bus.mem_axi3_rvalid_o, 1'b1);
    rd_n = 0;
    cyc  = 0;
    while (rd_n <= int'(len) && cyc < 64) begin
      bus.mem_axi3_rready_i = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      held = !bus.mem_axi3_rready_i;
      snap = {bus.mem_axi3_rvalid_o, bus.mem_axi3_rdata_o, bus.mem_axi3_rid_o,
              bus.mem_axi3_rresp_o, bus.mem_axi3_rlast_o};
      if (bus.mem_axi3_rready_i && bus.mem_axi3_rvalid_o) begin
        rd_data[rd_n] = bus.mem_axi3_rdata_o;
        rd_resp[rd_n] = bus.mem_axi3_rresp_o;
        rd_last[rd_n] = bus.mem_axi3_rlast_o;
        rd_id[rd_n]   = bus.mem_axi3_rid_o;
        rd_n++;
      end
      step();
      cyc++;
      if (held) begin
        check("r_hold_stall", {bus.mem_axi3_rvalid_o, bus.mem_axi3_rdata_o, bus.mem_axi3_rid_o,
                               bus.mem_axi3_rresp_o, bus.mem_axi3_rlast_o}, snap);
      end
    end
    rd_cyc = cyc;
    bus.mem_axi3_rready_i = 1'b1;
    check("arready_back", bus.mem_axi3_arready_o, 1'b1);
    check("rvalid_done", bus.mem_axi3_rvalid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    dat_a    = {8{32'hA1A2_A3A4}};
    dat_b    = {8{32'hB1B2_B3B4}};
    dat_p1   = {8{32'h0123_4567}};
    dat_w0   = {8{32'hDEAD_BEEF}};
    dat_w1   = {8{32'h5A5A_C3C3}};
    dat_m1   = {{7{32'h0123_4567}}, 32'hDEAD_BEEF};
    dat_old4 = {8{32'h4444_0000}};
    dat_new4 = {8{32'h4444_FFFF}};
    dat_x    = {8{32'hFFFF_0000}};

    rst = 1'b1;
    bus.mem_axi3_arvalid_i = 1'b0;  bus.mem_axi3_arid_i = 6'h00;    bus.mem_axi3_araddr_i = 32'h0;
    bus.mem_axi3_arlen_i   = 4'd0;  bus.mem_axi3_arsize_i = 3'd5;   bus.mem_axi3_arburst_i = 2'b01;
    bus.mem_axi3_rready_i  = 1'b1;
    bus.mem_axi3_awvalid_i = 1'b0;  bus.mem_axi3_awid_i = 6'h00;    bus.mem_axi3_awaddr_i = 32'h0;
    bus.mem_axi3_awlen_i   = 4'd0;  bus.mem_axi3_awsize_i = 3'd5;   bus.mem_axi3_awburst_i = 2'b01;
    bus.mem_axi3_wvalid_i  = 1'b0;  bus.mem_axi3_wid_i = 6'h00;     bus.mem_axi3_wdata_i = 256'h0;
    bus.mem_axi3_wstrb_i   = 32'h0; bus.mem_axi3_wlast_i = 1'b0;    bus.mem_axi3_bready_i = 1'b1;

    repeat (3) step();
    check("rst_arready", bus.mem_axi3_arready_o, 1'b1);
    check("rst_awready", bus.mem_axi3_awready_o, 1'b1);
    check("rst_rvalid",  bus.mem_axi3_rvalid_o,  1'b0);
    check("rst_rlast",   bus.mem_axi3_rlast_o,   1'b0);
    check("rst_wready",  bus.mem_axi3_wready_o,  1'b0);
    check("rst_bvalid",  bus.mem_axi3_bvalid_o,  1'b0);
    check("rst_rdata",   bus.mem_axi3_rdata_o,   256'h0);
    check("rst_rid",     bus.mem_axi3_rid_o,     6'h00);
    check("rst_rresp",   bus.mem_axi3_rresp_o,   2'b00);
    check("rst_bid",     bus.mem_axi3_bid_o,     6'h00);
    check("rst_bresp",   bus.mem_axi3_bresp_o,   2'b00);
    rst = 1'b0;
    step();

    // Preload mem[2]=A, mem[3]=B, mem[1]=P1, mem[4]=OLD4.
    wd[0] = dat_a;   ws[0] = 32'hFFFF_FFFF;
    wd[1] = dat_b;   ws[1] = 32'hFFFF_FFFF;
    axi_write(6'h00, 32'h0000_0040, 4'd1, 3'd5, 2'b01, 1, 6'h00);
    check("pre_ab_bresp", wr_bresp, 2'b00);
    wd[0] = dat_p1;
    axi_write(6'h00, 32'h0000_0020, 4'd0, 3'd5, 2'b01, 0, 6'h00);
    wd[0] = dat_old4;
    axi_write(6'h00, 32'h0000_0080, 4'd0, 3'd5, 2'b01, 0, 6'h00);

    // Two-beat INCR linefill.
    axi_read(6'h05, 32'h0000_0040, 4'd1, 3'd5, 2'b01, 1'b0);
    check("rd2_beats",  rd_n, 2);
    check("rd2_cycles", rd_cyc, 2);
    check("rd2_data0",  rd_data[0], dat_a);
    check("rd2_data1",  rd_data[1], dat_b);
    check("rd2_id",     rd_id[1], 6'h05);
    check("rd2_resp",   {rd_resp[0], rd_resp[1]}, 4'b0000);
    check("rd2_last",   {rd_last[0], rd_last[1]}, 2'b01);

    // Writeback with partial strobe on beat 0.
    wd[0] = dat_w0;  ws[0] = 32'h0000_000F;
    wd[1] = dat_w1;  ws[1] = 32'hFFFF_FFFF;
    axi_write(6'h11, 32'h0000_0020, 4'd1, 3'd5, 2'b01, 1, 6'h11);
    check("wb_bid",   wr_bid,   6'h11);
    check("wb_bresp", wr_bresp, 2'b00);

    // Four-beat read across mem[1..4] with rready 1,0,0,1,...
    axi_read(6'h09, 32'h0000_0020, 4'd3, 3'd5, 2'b01, 1'b1);
    check("rd4_beats", rd_n, 4);
    check("rd4_data0", rd_data[0], dat_m1);
    check("rd4_data1", rd_data[1], dat_w1);
    check("rd4_data2", rd_data[2], dat_b);
    check("rd4_data3", rd_data[3], dat_old4);
    check("rd4_last",  {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);

    // Illegal size on read.
    axi_read(6'h02, 32'h0000_0040, 4'd0, 3'd4, 2'b01, 1'b0);
    check("rdsz_beats", rd_n, 1);
    check("rdsz_resp",  rd_resp[0], 2'b10);
    check("rdsz_last",  rd_last[0], 1'b1);

    // WRAP write must not touch memory.
    wd[0] = dat_x;  ws[0] = 32'hFFFF_FFFF;
    axi_write(6'h03, 32'h0000_0040, 4'd0, 3'd5, 2'b10, 0, 6'h03);
    check("wrap_bresp", wr_bresp, 2'b10);
    axi_read(6'h03, 32'h0000_0040, 4'd0, 3'd5, 2'b01, 1'b0);
    check("wrap_mem_kept", rd_data[0], dat_w1);

    // WID mismatch and early WLAST.
    axi_write(6'h11, 32'h0000_00C0, 4'd0, 3'd5, 2'b01, 0, 6'h12);
    check("wid_mism_bresp", wr_bresp, 2'b10);
    check("wid_mism_bid",   wr_bid,   6'h11);
    axi_write(6'h03, 32'h0000_0100, 4'd1, 3'd5, 2'b01, 0, 6'h03);
    check("early_last_bresp", wr_bresp, 2'b10);

    // Same-cycle read and write of index 4.
    bus.mem_axi3_rready_i  = 1'b0;
    bus.mem_axi3_awid_i = 6'h07; bus.mem_axi3_awaddr_i = 32'h0000_0080; bus.mem_axi3_awlen_i = 4'd0;
    bus.mem_axi3_awsize_i = 3'd5; bus.mem_axi3_awburst_i = 2'b01; bus.mem_axi3_awvalid_i = 1'b1;
    bus.mem_axi3_arid_i = 6'h08; bus.mem_axi3_araddr_i = 32'h0000_0080; bus.mem_axi3_arlen_i = 4'd0;
    bus.mem_axi3_arsize_i = 3'd5; bus.mem_axi3_arburst_i = 2'b01; bus.mem_axi3_arvalid_i = 1'b1;
    step();
    bus.mem_axi3_awvalid_i = 1'b0;
    bus.mem_axi3_arvalid_i = 1'b0;
    check("ovl_rvalid", bus.mem_axi3_rvalid_o, 1'b1);
    check("ovl_wready", bus.mem_axi3_wready_o, 1'b1);
    bus.mem_axi3_wvalid_i = 1'b1; bus.mem_axi3_wdata_i = dat_new4; bus.mem_axi3_wstrb_i = 32'hFFFF_FFFF;
    bus.mem_axi3_wlast_i  = 1'b1; bus.mem_axi3_wid_i = 6'h07;
    bus.mem_axi3_rready_i = 1'b1;
    check("ovl_rdata_old", bus.mem_axi3_rdata_o, dat_old4);
    step();
    bus.mem_axi3_wvalid_i = 1'b0;
    bus.mem_axi3_wlast_i  = 1'b0;
    check("ovl_bvalid", bus.mem_axi3_bvalid_o, 1'b1);
    check("ovl_bresp",  bus.mem_axi3_bresp_o,  2'b00);
    check("ovl_rdone",  bus.mem_axi3_rvalid_o, 1'b0);
    step();
    axi_read(6'h08, 32'h0000_0080, 4'd0, 3'd5, 2'b01, 1'b0);
    check("ovl_rdata_new", rd_data[0], dat_new4);

    // Reset in the middle of a read burst.
    bus.mem_axi3_rready_i = 1'b0;
    bus.mem_axi3_arid_i = 6'h0A; bus.mem_axi3_araddr_i = 32'h0000_0020; bus.mem_axi3_arlen_i = 4'd3;
    bus.mem_axi3_arsize_i = 3'd5; bus.mem_axi3_arburst_i = 2'b01; bus.mem_axi3_arvalid_i = 1'b1;
    step();
    bus.mem_axi3_arvalid_i = 1'b0;
    check("mid_rvalid_pre", bus.mem_axi3_rvalid_o, 1'b1);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid",  bus.mem_axi3_rvalid_o,  1'b0);
    check("mid_rst_arready", bus.mem_axi3_arready_o, 1'b1);
    check("mid_rst_rlast",   bus.mem_axi3_rlast_o,   1'b0);
    step();
    rst = 1'b0;
    bus.mem_axi3_rready_i = 1'b1;
    step();
    check("post_rst_no_r", bus.mem_axi3_rvalid_o, 1'b0);
    check("post_rst_no_b", bus.mem_axi3_bvalid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
